// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
//   - uart_state_e  : receiver FSM states
//   - PRESCALE_X*   : legal oversampling ratios
//   - START_BIT / STOP_BIT : frame delimiter levels
//   - majority3     : 2-of-3 vote used by the bit sampler
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned PRESCALE_X8  = 8;
  localparam int unsigned PRESCALE_X16 = 16;
  localparam int unsigned PRESCALE_X32 = 32;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/edge_bit_counter.sv
// Oversampling edge counter and bit counter for the UART receiver.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : advance the edge counter this cycle
//   i_clr          : force both counters to 0 (wins over i_en)
//   i_prescale     : cycles per bit; edge counter wraps at i_prescale-1
//   o_edge_cnt     : position within the current bit
//   o_bit_cnt      : bits completed since the last clear
module edge_bit_counter #(
  parameter int unsigned EDGE_W = 6,
  parameter int unsigned BIT_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_clr,
  input  logic [EDGE_W-1:0] i_prescale,
  output logic [EDGE_W-1:0] o_edge_cnt,
  output logic [BIT_W-1:0]  o_bit_cnt
);

  logic [EDGE_W-1:0] r_edge_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic              w_wrap;

  assign w_wrap     = (r_edge_cnt == (i_prescale - EDGE_W'(1)));
  assign o_edge_cnt = r_edge_cnt;
  assign o_bit_cnt  = r_bit_cnt;

  // Edge counter wraps once per bit period and carries into the bit counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_clr) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_en) begin
      if (w_wrap) begin
        r_edge_cnt <= '0;
        r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
      end else begin
        r_edge_cnt <= r_edge_cnt + EDGE_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, WIDTH data bits LSB first, optional parity, one stop.
// Each bit is a 2-of-3 majority of RX_IN taken around the bit centre.
//   CLK, RST    : oversampling clock, async active-low reset
//   RX_IN       : serial line (idle high, already synchronous to CLK)
//   PAR_EN      : frame carries a parity bit
//   PAR_TYP     : 0 = even, 1 = odd parity
//   Prescale    : oversampling ratio (8, 16 or 32)
//   P_DATA      : last error-free received word
//   DATA_VALID  : one-cycle pulse when P_DATA is updated
//   PAR_ERR     : one-cycle pulse on parity mismatch
//   STP_ERR     : one-cycle pulse when the stop bit samples low
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [WIDTH-1:0]      P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int unsigned BIT_CNT_W = $clog2(WIDTH + 1);

  uart_state_e           r_state;
  logic [PRESCALE_W-1:0] r_prescale;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic [WIDTH-1:0]      r_shift;
  logic [2:0]            r_smp;
  logic                  r_par_bad;

  logic [PRESCALE_W-1:0] w_edge_cnt;
  logic [PRESCALE_W-1:0] w_half;
  logic [BIT_CNT_W-1:0]  w_bit_cnt;
  logic                  w_start_det;
  logic                  w_bit_end;
  logic                  w_decide;
  logic                  w_maj;
  logic                  w_cnt_en;
  logic                  w_cnt_clr;

  assign w_half      = r_prescale >> 1;
  assign w_start_det = (r_state == ST_IDLE) && (RX_IN == START_BIT);
  assign w_bit_end   = (w_edge_cnt == (r_prescale - PRESCALE_W'(1)));
  assign w_decide    = (w_edge_cnt == (w_half + PRESCALE_W'(2)));
  assign w_maj       = majority3(r_smp);

  // Counting starts in the start-detect cycle so that cycle is edge 0.
  // Clearing at the decision point of START (glitch) or STOP returns to IDLE
  // half a bit early, ready for a back-to-back start edge.
  assign w_cnt_en  = w_start_det || (r_state != ST_IDLE);
  assign w_cnt_clr = w_decide &&
                     (((r_state == ST_START) && (w_maj != START_BIT)) ||
                      (r_state == ST_STOP));

  edge_bit_counter #(
    .EDGE_W (PRESCALE_W),
    .BIT_W  (BIT_CNT_W)
  ) u_cnt (
    .i_clk      (CLK),
    .i_rst_n    (RST),
    .i_en       (w_cnt_en),
    .i_clr      (w_cnt_clr),
    .i_prescale (r_prescale),
    .o_edge_cnt (w_edge_cnt),
    .o_bit_cnt  (w_bit_cnt)
  );

  // Receive FSM with sampler, shift register, parity check and output pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_prescale <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_shift    <= '0;
      r_smp      <= '0;
      r_par_bad  <= 1'b0;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;

      // Three captures straddling the bit centre.
      if (r_state != ST_IDLE) begin
        if (w_edge_cnt == (w_half - PRESCALE_W'(1))) r_smp[0] <= RX_IN;
        if (w_edge_cnt == w_half)                    r_smp[1] <= RX_IN;
        if (w_edge_cnt == (w_half + PRESCALE_W'(1))) r_smp[2] <= RX_IN;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_start_det) begin
            r_prescale <= Prescale;
            r_par_en   <= PAR_EN;
            r_par_typ  <= PAR_TYP;
            r_par_bad  <= 1'b0;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          if (w_decide && (w_maj != START_BIT)) begin
            r_state <= ST_IDLE;
          end else if (w_bit_end) begin
            r_state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_decide) begin
            r_shift <= WIDTH'({w_maj, r_shift} >> 1);
          end
          if (w_bit_end && (w_bit_cnt == BIT_CNT_W'(WIDTH))) begin
            r_state <= r_par_en ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (w_decide) begin
            r_par_bad <= (w_maj != ((^r_shift) ^ r_par_typ));
          end
          if (w_bit_end) begin
            r_state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (w_decide) begin
            if ((w_maj == STOP_BIT) && !r_par_bad) begin
              P_DATA     <= r_shift;
              DATA_VALID <= 1'b1;
            end
            PAR_ERR <= r_par_bad;
            STP_ERR <= (w_maj != STOP_BIT);
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit on the falling
// edge; a falling-edge monitor records every output pulse with its cycle.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  int         dv_cnt, pe_cnt, se_cnt;
  int         dv_cyc0, dv_cyc1, pe_cyc, se_cyc;
  logic [7:0] dv_dat0, dv_dat1;

  uart_rx #(.WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .Prescale   (Prescale),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_ERR    (PAR_ERR),
    .STP_ERR    (STP_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Pulse monitor: counts high cycles so a stretched pulse is visible.
  always @(negedge CLK) begin
    if (DATA_VALID) begin
      if (dv_cnt == 0) begin
        dv_cyc0 = cyc;
        dv_dat0 = P_DATA;
      end
      dv_cyc1 = cyc;
      dv_dat1 = P_DATA;
      dv_cnt  = dv_cnt + 1;
    end
    if (PAR_ERR) begin
      pe_cyc = cyc;
      pe_cnt = pe_cnt + 1;
    end
    if (STP_ERR) begin
      se_cyc = cyc;
      se_cnt = se_cnt + 1;
    end
  end

  task automatic clear_mon();
    dv_cnt = 0; pe_cnt = 0; se_cnt = 0;
    dv_cyc0 = -1; dv_cyc1 = -1; pe_cyc = -1; se_cyc = -1;
    dv_dat0 = 8'h00; dv_dat1 = 8'h00;
  endtask

  task automatic drive_bit(input logic b, input int p);
    RX_IN = b;
    repeat (p) @(negedge CLK);
  endtask

  // Called on a falling edge; returns the start-detect cycle in s.
  // scramble changes the config inputs after the start bit to prove latching.
  task automatic send_frame(input int p, input logic [7:0] d, input logic pe,
                            input logic pt, input logic par_bit, input logic stop,
                            input logic scramble, output int s);
    Prescale = 6'(p);
    PAR_EN   = pe;
    PAR_TYP  = pt;
    s = cyc;
    drive_bit(1'b0, p);
    if (scramble) begin
      Prescale = (p == 8) ? 6'd16 : 6'd8;
      PAR_EN   = ~pe;
      PAR_TYP  = ~pt;
    end
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pe) drive_bit(par_bit, p);
    drive_bit(stop, p);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_vec++; if (P_DATA !== 8'h00) begin n_err++; $display("FAIL reset_pdata got=%h exp=00", P_DATA); end
    n_vec++; if (DATA_VALID !== 1'b0) begin n_err++; $display("FAIL reset_dv got=%b exp=0", DATA_VALID); end
    n_vec++; if (PAR_ERR !== 1'b0) begin n_err++; $display("FAIL reset_pe got=%b exp=0", PAR_ERR); end
    n_vec++; if (STP_ERR !== 1'b0) begin n_err++; $display("FAIL reset_se got=%b exp=0", STP_ERR); end
    RST = 1'b1;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_even_parity();
    int s;
    clear_mon();
    send_frame(8, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, s);
    repeat (8) @(negedge CLK);
    n_vec++; if (dv_cnt !== 1) begin n_err++; $display("FAIL t1_dv_count got=%0d exp=1", dv_cnt); end
    n_vec++; if (dv_cyc0 !== s + 87) begin n_err++; $display("FAIL t1_dv_cycle got=%0d exp=%0d", dv_cyc0, s + 87); end
    n_vec++; if (dv_dat0 !== 8'hA5) begin n_err++; $display("FAIL t1_data got=%h exp=a5", dv_dat0); end
    n_vec++; if (pe_cnt !== 0) begin n_err++; $display("FAIL t1_pe_count got=%0d exp=0", pe_cnt); end
    n_vec++; if (se_cnt !== 0) begin n_err++; $display("FAIL t1_se_count got=%0d exp=0", se_cnt); end
  endtask

  task automatic test_parity_error();
    int s;
    clear_mon();
    send_frame(16, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, s);
    repeat (8) @(negedge CLK);
    n_vec++; if (pe_cnt !== 1) begin n_err++; $display("FAIL t2_pe_count got=%0d exp=1", pe_cnt); end
    n_vec++; if (pe_cyc !== s + 171) begin n_err++; $display("FAIL t2_pe_cycle got=%0d exp=%0d", pe_cyc, s + 171); end
    n_vec++; if (dv_cnt !== 0) begin n_err++; $display("FAIL t2_dv_count got=%0d exp=0", dv_cnt); end
    n_vec++; if (se_cnt !== 0) begin n_err++; $display("FAIL t2_se_count got=%0d exp=0", se_cnt); end
    n_vec++; if (P_DATA !== 8'hA5) begin n_err++; $display("FAIL t2_pdata_kept got=%h exp=a5", P_DATA); end
  endtask

  task automatic test_stop_error();
    int s;
    clear_mon();
    send_frame(32, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, s);
    RX_IN = 1'b1;
    repeat (64) @(negedge CLK);
    n_vec++; if (se_cnt !== 1) begin n_err++; $display("FAIL t3_se_count got=%0d exp=1", se_cnt); end
    n_vec++; if (se_cyc !== s + 307) begin n_err++; $display("FAIL t3_se_cycle got=%0d exp=%0d", se_cyc, s + 307); end
    n_vec++; if (dv_cnt !== 0 || pe_cnt !== 0) begin n_err++; $display("FAIL t3_no_other dv=%0d pe=%0d exp=0/0", dv_cnt, pe_cnt); end
    n_vec++; if (P_DATA !== 8'hA5) begin n_err++; $display("FAIL t3_pdata_kept got=%h exp=a5", P_DATA); end
    clear_mon();
    send_frame(32, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, s);
    repeat (8) @(negedge CLK);
    n_vec++; if (dv_cnt !== 1) begin n_err++; $display("FAIL t3_dv_count got=%0d exp=1", dv_cnt); end
    n_vec++; if (dv_cyc0 !== s + 307) begin n_err++; $display("FAIL t3_dv_cycle got=%0d exp=%0d", dv_cyc0, s + 307); end
    n_vec++; if (P_DATA !== 8'h7E) begin n_err++; $display("FAIL t3_data got=%h exp=7e", P_DATA); end
  endtask

  task automatic test_glitch();
    int s;
    clear_mon();
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    RX_IN = 1'b0;
    repeat (2) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (24) @(negedge CLK);
    n_vec++; if (dv_cnt !== 0) begin n_err++; $display("FAIL t4_glitch_dv got=%0d exp=0", dv_cnt); end
    n_vec++; if (pe_cnt !== 0 || se_cnt !== 0) begin n_err++; $display("FAIL t4_glitch_err pe=%0d se=%0d exp=0/0", pe_cnt, se_cnt); end
    send_frame(8, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s);
    repeat (8) @(negedge CLK);
    n_vec++; if (dv_cnt !== 1) begin n_err++; $display("FAIL t4_dv_count got=%0d exp=1", dv_cnt); end
    n_vec++; if (dv_cyc0 !== s + 79) begin n_err++; $display("FAIL t4_dv_cycle got=%0d exp=%0d", dv_cyc0, s + 79); end
    n_vec++; if (dv_dat0 !== 8'h55) begin n_err++; $display("FAIL t4_data got=%h exp=55", dv_dat0); end
  endtask

  task automatic test_back_to_back();
    int s1, s2;
    clear_mon();
    send_frame(16, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s1);
    send_frame(16, 8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s2);
    repeat (16) @(negedge CLK);
    n_vec++; if (dv_cnt !== 2) begin n_err++; $display("FAIL t5_dv_count got=%0d exp=2", dv_cnt); end
    n_vec++; if (dv_cyc0 !== s1 + 155) begin n_err++; $display("FAIL t5_first_cycle got=%0d exp=%0d", dv_cyc0, s1 + 155); end
    n_vec++; if (dv_cyc1 - dv_cyc0 !== 160) begin n_err++; $display("FAIL t5_spacing got=%0d exp=160", dv_cyc1 - dv_cyc0); end
    n_vec++; if (dv_dat0 !== 8'h12) begin n_err++; $display("FAIL t5_data0 got=%h exp=12", dv_dat0); end
    n_vec++; if (dv_dat1 !== 8'h34) begin n_err++; $display("FAIL t5_data1 got=%h exp=34", dv_dat1); end
  endtask

  task automatic test_reset_abort();
    int s;
    logic [7:0] d;
    d = 8'hF0;
    clear_mon();
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 8);
    RX_IN = d[4];
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_vec++; if (P_DATA !== 8'h00) begin n_err++; $display("FAIL t6_rst_pdata got=%h exp=00", P_DATA); end
    n_vec++; if ({DATA_VALID, PAR_ERR, STP_ERR} !== 3'b000) begin n_err++; $display("FAIL t6_rst_pulses got=%b exp=000", {DATA_VALID, PAR_ERR, STP_ERR}); end
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (100) @(negedge CLK);
    n_vec++; if (dv_cnt + pe_cnt + se_cnt !== 0) begin n_err++; $display("FAIL t6_abort_silent dv=%0d pe=%0d se=%0d exp=0", dv_cnt, pe_cnt, se_cnt); end
    send_frame(8, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, s);
    repeat (8) @(negedge CLK);
    n_vec++; if (dv_cnt !== 1) begin n_err++; $display("FAIL t6_dv_count got=%0d exp=1", dv_cnt); end
    n_vec++; if (dv_cyc0 !== s + 79) begin n_err++; $display("FAIL t6_dv_cycle got=%0d exp=%0d", dv_cyc0, s + 79); end
    n_vec++; if (P_DATA !== 8'h0F) begin n_err++; $display("FAIL t6_data got=%h exp=0f", P_DATA); end
  endtask

  initial begin
    RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd8;
    clear_mon();
    test_reset();
    test_even_parity();
    test_parity_error();
    test_stop_error();
    test_glitch();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver: the receive-side counterpart of the team's UART transmitter, using the same frame format.
- Frame: start(0), WIDTH data bits LSB first, optional parity, one stop(1).
- RX_IN is oversampled by a runtime Prescale; each bit is decided by a 3-sample majority vote.
- Delivers the received word on P_DATA with a one-cycle DATA_VALID pulse to the system controller, and flags parity and stop errors.

Parameters:
- WIDTH, 8, data bits per frame.
- PRESCALE_W, 6, width of the Prescale input.

Ports:
- CLK  input  1  receive oversampling clock.
- RST  input  1  asynchronous active-low reset.
- RX_IN  input  1  serial line; idles high; already synchronous to CLK (synchronized upstream).
- PAR_EN  input  1  1 = frame carries a parity bit.
- PAR_TYP  input  1  0 = even, 1 = odd.
- Prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
- P_DATA  output  WIDTH  last good received word.
- DATA_VALID  output  1  one-cycle pulse: P_DATA updated with an error-free frame.
- PAR_ERR  output  1  one-cycle pulse: parity mismatch.
- STP_ERR  output  1  one-cycle pulse: stop bit sampled 0.

Behaviour:
- Reset (RST=0, async):
  - All outputs 0; P_DATA = 0.
  - State IDLE, counters 0.
  - Reset mid-frame aborts the frame silently; no pulses are emitted.
- Config latch: Prescale, PAR_EN and PAR_TYP are latched on start detection and are ignored for the rest of the frame.
- Timing:
  - Let P = latched Prescale and S = the cycle in IDLE where RX_IN==0.
  - Cycle S is edge_cnt=0 of the start bit; each bit spans P cycles (edge_cnt 0..P-1, then bit_cnt+1).
- Sampling:
  - RX_IN is captured at edge_cnt = P/2-1, P/2 and P/2+1.
  - The bit value is the majority of the three captures, valid at edge_cnt = P/2+2.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: RX_IN==0 -> START, edge_cnt=0.
  - START: at edge_cnt=P/2+2, a start value of 1 is a glitch -> IDLE with no pulses. A value of 0 -> DATA at end of bit (edge_cnt=P-1).
  - DATA: shift sampled bits in LSB first. After WIDTH bits -> PARITY if PAR_EN, else STOP.
  - PARITY: compare the sample to the XOR of the data bits (inverted when odd); record the mismatch. At end of bit -> STOP.
  - STOP: at edge_cnt=P/2+2, evaluate and go to IDLE. Returning half a bit early allows resync to a back-to-back start edge.
- Outputs (registered; asserted in cycle S + (1+WIDTH+PAR_EN)*P + P/2 + 3, for exactly one cycle):
  - No errors: P_DATA <= shift register; DATA_VALID=1.
  - Parity mismatch: PAR_ERR=1, P_DATA unchanged, no DATA_VALID.
  - Stop sample 0: STP_ERR=1, P_DATA unchanged, no DATA_VALID.
  - PAR_ERR and STP_ERR may pulse together.
  - PAR_ERR never pulses when PAR_EN=0.
- Line held low after a stop error: the block returns to IDLE, then immediately re-detects a start. A permanently low line therefore gives a repeated stop error every frame period; this is acceptable.
- Illegal Prescale (not 8/16/32): behaviour undefined; the bench does not drive it.
- Counter widths:
  - edge_cnt: PRESCALE_W bits.
  - bit_cnt: clog2(WIDTH+1) bits.
  - Both counters wrap only under explicit FSM control.

Decomposition:
- Shared package (uart_pkg):
  - FSM state enumeration.
  - Legal Prescale constants (8/16/32).
  - Frame-bit constants START_BIT=0, STOP_BIT=1. The transmitter uses the same constants.
- Sub-module edge_bit_counter: edge_cnt/bit_cnt with enable and P-wrap.
- Majority sampler and parity check stay inline in uart_rx.

Test Plan:
1. Prescale=8, PAR_EN=1, PAR_TYP=0: send 8'hA5 with parity 0 and stop 1 -> P_DATA=8'hA5. DATA_VALID pulses once at S+87, i.e. S + (1+8+1)*8 + 4 + 3. PAR_ERR=STP_ERR=0.
2. Prescale=16, PAR_EN=1, PAR_TYP=1: send 8'h3C with parity bit 0 (wrong; odd requires 1) -> PAR_ERR pulse, no DATA_VALID, P_DATA keeps its previous value.
3. Prescale=32, PAR_EN=0: send 8'h81 with stop bit driven 0 -> STP_ERR one-cycle pulse, no DATA_VALID. Then a correct frame 8'h7E -> DATA_VALID, P_DATA=8'h7E.
4. Prescale=8: RX_IN low for 2 cycles then high (glitch) -> back in IDLE, no pulses. A following valid 8'h55 frame is received correctly.
5. Prescale=16, PAR_EN=0: frames 8'h12 and 8'h34 back-to-back (no idle gap) -> two DATA_VALID pulses 160 cycles apart, data 8'h12 then 8'h34.
6. Prescale=8: assert RST=0 mid data bit 4 of 8'hF0, release, then send 8'h0F -> no pulse for the aborted frame, outputs 0 during reset, then DATA_VALID with P_DATA=8'h0F.
